mem_arb_multi_ch: RTL

- Parametrised successor to the team's single-port valid/ready memory.
- Shares one WIDTH x DEPTH synchronous memory among NUM_CH requestor channels through a round-robin arbiter.
- Adds byte-enable writes, an out-of-range error response, and one access per cycle across channels.
- Sits between multiple bus masters (DMA, CPU-side agents) and a shared scratch RAM.

---
 rtl/mem_arb_multi_ch_if.sv | 27 ++
 rtl/mem_arb_multi_ch.sv | 86 ++++++++
 2 files changed

// File: rtl/mem_arb_multi_ch_if.sv
// Request/response bundle for the multi-channel shared memory; channel c owns slice c of every field.
// The master drives the requests and the slave returns the one-cycle completion pulses.
interface mem_arb_multi_ch_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_CH     = 2,
    parameter int BE_WIDTH   = WIDTH / 8
);
    logic [NUM_CH-1:0]            valid;
    logic [NUM_CH-1:0]            wr_rd;
    logic [NUM_CH*ADDR_WIDTH-1:0] addr;
    logic [NUM_CH*WIDTH-1:0]      w_data;
    logic [NUM_CH*BE_WIDTH-1:0]   be;
    logic [NUM_CH*WIDTH-1:0]      r_data;
    logic [NUM_CH-1:0]            ready;
    logic [NUM_CH-1:0]            err;

    modport master (
        output valid, wr_rd, addr, w_data, be,
        input  r_data, ready, err
    );

    modport slave (
        input  valid, wr_rd, addr, w_data, be,
        output r_data, ready, err
    );
endinterface

// File: rtl/mem_arb_multi_ch.sv
// Round-robin shared byte-enable RAM: one access per cycle, ready/err/r_data registered one cycle after grant.
// Ungranted channels simply keep valid high and wait; there is no timeout and no request queueing.
module mem_arb_multi_ch #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_CH     = 2,
    parameter int BE_WIDTH   = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,
    mem_arb_multi_ch_if.slave bus
);
    localparam int                    PTR_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]        r_ptr;
    logic [NUM_CH-1:0]       r_ready;
    logic [NUM_CH-1:0]       r_err;
    logic [NUM_CH*WIDTH-1:0] r_rdata;

    logic [NUM_CH-1:0]       w_elig;
    logic                    w_gnt_vld;
    logic [PTR_W-1:0]        w_gnt;
    logic                    w_gnt_wr;
    logic [ADDR_WIDTH-1:0]   w_gnt_addr;
    logic [WIDTH-1:0]        w_gnt_wdata;
    logic [BE_WIDTH-1:0]     w_gnt_be;
    logic                    w_gnt_oor;

    // A channel still showing its completion pulse must not be granted the same request again.
    assign w_elig = bus.valid & ~r_ready;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = r_ptr;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!w_gnt_vld && w_elig[PTR_W'((int'(r_ptr) + k) % NUM_CH)]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = PTR_W'((int'(r_ptr) + k) % NUM_CH);
            end
        end
    end

    assign w_gnt_wr    = bus.wr_rd[w_gnt];
    assign w_gnt_addr  = bus.addr[int'(w_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_gnt_wdata = bus.w_data[int'(w_gnt)*WIDTH +: WIDTH];
    assign w_gnt_be    = bus.be[int'(w_gnt)*BE_WIDTH +: BE_WIDTH];
    assign w_gnt_oor   = ({1'b0, w_gnt_addr} >= DEPTH_EXT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr   <= PTR_W'(NUM_CH - 1);
            r_ready <= '0;
            r_err   <= '0;
            r_rdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_ready <= '0;
            r_err   <= '0;
            r_rdata <= '0;
            if (w_gnt_vld) begin
                r_ptr          <= w_gnt;
                r_ready[w_gnt] <= 1'b1;
                if (w_gnt_oor) begin
                    r_err[w_gnt] <= 1'b1;
                end else if (w_gnt_wr) begin
                    for (int b = 0; b < BE_WIDTH; b++) begin
                        if (w_gnt_be[b]) begin
                            r_mem[w_gnt_addr][8*b +: 8] <= w_gnt_wdata[8*b +: 8];
                        end
                    end
                end else begin
                    r_rdata[int'(w_gnt)*WIDTH +: WIDTH] <= r_mem[w_gnt_addr];
                end
            end
        end
    end

    assign bus.ready  = r_ready;
    assign bus.err    = r_err;
    assign bus.r_data = r_rdata;
endmodule
